multi_16bit: RTL and testbench
==============================

Name: multi_16bit

Overview:
Sequential shift-and-add unsigned multiplier, 16x16 -> 32 bits, with a level start/done handshake. It is used as a small, area-cheap arithmetic unit that a controlling FSM drives. The controller raises start, holds it until done, then drops it. One partial product is accumulated per clock.

Parameters:
WIDTH, 16, operand width in bits; product width is 2*WIDTH. Only 16 is verified.

Ports:
clk    input   1   rising-edge clock, single clock domain
rst_n  input   1   synchronous active-low reset, sampled on rising clk
start  input   1   level request; held high by the controller until done, then dropped
ain    input   16  multiplicand, unsigned; sampled only on accepted start
bin    input   16  multiplier, unsigned; sampled only on accepted start
yout   output  32  product, unsigned, registered
done   output  1   registered; high when yout holds a valid product for the current request

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, done=0, yout=0, counter=0, internal operand and accumulator registers=0. Reset has priority over every other event, including mid-operation.
- States: IDLE, RUN, DONE.
- IDLE: on an edge with start=1:
  - latch a_reg=ain (zero-extended to 32 bits) and b_reg=bin;
  - clear the accumulator and counter=0;
  - go to RUN.
  - done stays 0. With start=0 the block stays in IDLE and yout holds its value.
- RUN: one iteration per clock:
  - if b_reg[0]=1, accumulator += a_reg;
  - then a_reg <<= 1, b_reg >>= 1, counter += 1.
  - After the 16th iteration (counter reaches 16): yout=accumulator, done=1, go to DONE.
  - Accumulator arithmetic is 32-bit and cannot overflow (max 0xFFFE0001).
- Latency: done rises on the 17th rising edge after the first edge that samples start=1 (1 load cycle + 16 iteration cycles). Latency is fixed and independent of operand values.
- DONE: done=1 and yout stable while start=1. On an edge with start=0: done=0, go to IDLE; yout keeps the product.
- start dropped during RUN: abort; next edge returns to IDLE, done stays 0, yout unchanged (previous value).
- ain/bin changes after the load edge have no effect on the result.
- A new operation needs start=0 for at least one edge (return to IDLE) before start=1 is accepted again.
- done is never high in IDLE or RUN.
- All outputs are driven from registers; there are no combinational paths from inputs to outputs.

Optional Feature:
Macro MULTI_EARLY_DONE_EN.
- Defined: in RUN, if the shifted b_reg is zero after an iteration (no further set bits), finish immediately: yout=accumulator, done=1, go to DONE. Latency becomes 1 + max(1, index of highest set bit of bin + 1) edges. bin=0 gives done on the 2nd edge.
- Not defined: fixed 17-edge latency as above.
- Product values are identical in both builds.

Test Plan:
- Reset, then ain=3, bin=5, start=1 held -> done=1 on the 17th edge, yout=0x0000000F; drop start -> done=0 next edge, yout stays 0x0F.
- ain=0xFFFF, bin=0xFFFF -> yout=0xFFFE0001 with done=1; ain=0x0000, bin=0x1234 -> yout=0 with done=1 (17 edges, or 2 edges with MULTI_EARLY_DONE_EN only if bin=0).
- Reset asserted at iteration 8 of ain=0x1234, bin=0x5678 -> next edge done=0, yout=0; release reset with start=0 -> block stays IDLE.
- start dropped at iteration 5 (previous yout=0x0F) -> IDLE, done never rises, yout=0x0F; restart with ain=0x00FF, bin=0x0101 -> yout=0x0000FFFF.
- Change ain/bin every cycle during RUN after loading ain=0x8000, bin=0x0002 -> yout=0x00010000.
- 1000 random operand pairs, each followed by start low plus reset between ops -> yout == ain*bin on every done.

Source files
------------

// File: rtl/multi_16bit.sv
// multi_16bit: sequential shift-and-add unsigned multiplier, WIDTH x WIDTH -> 2*WIDTH.
// A level start/done handshake is used. The controller holds start high until done
// rises, then drops it. One partial product is accumulated per clock.
// Optional build macro MULTI_EARLY_DONE_EN: finish as soon as no set multiplier bits
// remain, so latency depends on the operand. Product values are the same in both builds.
// Reset is synchronous and active-low (rst_n), sampled on the rising edge of clk.

module multi_16bit #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   ain,
    input  logic [WIDTH-1:0]   bin,
    output logic [2*WIDTH-1:0] yout,
    output logic               done
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [PW-1:0]    a_reg;
    logic [PW-1:0]    acc;
    logic [WIDTH-1:0] b_reg;
    logic [CW-1:0]    count;

    logic [PW-1:0]    acc_next;
    logic [WIDTH-1:0] b_next;
    logic             last_iter;

    // Next accumulator and multiplier values for one iteration, plus the finish condition.
    always_comb begin
        acc_next  = acc;
        b_next    = b_reg >> 1;
        last_iter = 1'b0;
        if (b_reg[0]) begin
            acc_next = acc + a_reg;
        end
`ifdef MULTI_EARLY_DONE_EN
        last_iter = (count == CW'(WIDTH - 1)) || (b_next == '0);
`else
        last_iter = (count == CW'(WIDTH - 1));
`endif
    end

    // Control FSM and datapath registers. Reset takes priority over every other event.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            a_reg <= '0;
            b_reg <= '0;
            acc   <= '0;
            count <= '0;
            yout  <= '0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_reg <= PW'(ain);
                        b_reg <= bin;
                        acc   <= '0;
                        count <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (!start) begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        acc   <= acc_next;
                        a_reg <= a_reg << 1;
                        b_reg <= b_next;
                        count <= count + CW'(1);
                        if (last_iter) begin
                            yout  <= acc_next;
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (!start) begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multi_16bit.sv
// tb_multi_16bit: scoreboard bench for multi_16bit.
// Stimulus pushes the expected product and the edge on which done must rise.
// A monitor pops and compares on every rising edge of done.

module tb_multi_16bit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] ain;
    logic [15:0] bin;
    logic [31:0] yout;
    logic        done;

    typedef struct {
        logic [31:0] prod;
        int          edge_no;
    } exp_t;

    exp_t        sb[$];
    int          tests_run = 0;
    int          failures  = 0;
    int          edge_cnt  = 0;
    logic        done_q    = 1'b0;
    logic [31:0] last_prod = 32'h0;

    multi_16bit #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .ain   (ain),
        .bin   (bin),
        .yout  (yout),
        .done  (done)
    );

    // Free-running clock with a 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count rising edges so latency can be checked in absolute terms.
    always @(posedge clk) begin
        edge_cnt++;
    end

    // Reference latency, in edges from the first edge that samples start.
    function automatic int model_latency(input logic [15:0] b);
        int top;
        top = 0;
        for (int i = 0; i < 16; i++) begin
            if (b[i]) top = i + 1;
        end
`ifdef MULTI_EARLY_DONE_EN
        return 1 + ((top < 1) ? 1 : top);
`else
        return 17;
`endif
    endfunction

    // Monitor: on each rising edge of done, pop the scoreboard and compare.
    always @(negedge clk) begin
        exp_t e;
        if (done && !done_q) begin
            tests_run++;
            if (sb.size() == 0) begin
                failures++;
                $display("[TB] FAIL unexpected_done: done=1 yout=%h, no request pending", yout);
            end else begin
                e = sb.pop_front();
                if (yout !== e.prod) begin
                    failures++;
                    $display("[TB] FAIL product: yout=%h expected=%h", yout, e.prod);
                end
                tests_run++;
                if (edge_cnt != e.edge_no) begin
                    failures++;
                    $display("[TB] FAIL latency: done rose at edge %0d expected edge %0d",
                             edge_cnt, e.edge_no);
                end
            end
        end
        done_q = done;
    end

    // Compare outputs against expected values at a quiet point after an edge.
    task automatic checkOutput(input string name, input logic [31:0] exp_y, input logic exp_d);
        tests_run++;
        if (yout !== exp_y || done !== exp_d) begin
            failures++;
            $display("[TB] FAIL %s: yout=%h done=%b expected yout=%h done=%b",
                     name, yout, done, exp_y, exp_d);
        end
    endtask

    // Present operands and raise start just after an edge; the next edge loads them.
    task automatic startOp(input logic [15:0] a, input logic [15:0] b);
        @(posedge clk);
        #1;
        ain   = a;
        bin   = b;
        start = 1'b1;
    endtask

    // Full handshake: issue request, wait for done, drop start and check hold behaviour.
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input bit scramble);
        exp_t        e;
        bit          got;
        logic [31:0] prod;
        prod = 32'(a) * 32'(b);
        startOp(a, b);
        e.prod    = prod;
        e.edge_no = edge_cnt + model_latency(b);
        sb.push_back(e);
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (scramble) begin
                ain = 16'($urandom);
                bin = 16'($urandom);
            end
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            tests_run++;
            failures++;
            $display("[TB] FAIL timeout: done not seen for a=%h b=%h", a, b);
            sb.delete();
        end
        start = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("drop_start", prod, 1'b0);
        last_prod = prod;
    endtask

    // Safety net so the run always terminates.
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main stimulus sequence.
    initial begin
        logic [15:0] a;
        logic [15:0] b;
        rst_n = 1'b0;
        start = 1'b0;
        ain   = 16'h0;
        bin   = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_state", 32'h0, 1'b0);
        rst_n = 1'b1;

        applyStimulus(16'd3, 16'd5, 1'b0);
        checkOutput("basic_hold", 32'h0000_000F, 1'b0);

        applyStimulus(16'hFFFF, 16'hFFFF, 1'b0);
        checkOutput("max_operands", 32'hFFFE_0001, 1'b0);
        applyStimulus(16'h0000, 16'h1234, 1'b0);
        applyStimulus(16'h1234, 16'h0000, 1'b0);

        // Reset in the middle of an operation.
        startOp(16'h1234, 16'h5678);
        @(posedge clk);
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("reset_mid_op", 32'h0, 1'b0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("idle_after_reset", 32'h0, 1'b0);

        // Abort by dropping start mid-run; the previous product must survive.
        applyStimulus(16'd3, 16'd5, 1'b0);
        startOp(16'h1234, 16'h5678);
        @(posedge clk);
        repeat (5) @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("abort", 32'h0000_000F, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        checkOutput("abort_idle", 32'h0000_000F, 1'b0);
        applyStimulus(16'h00FF, 16'h0101, 1'b0);
        checkOutput("restart", 32'h0000_FFFF, 1'b0);

        // Operands changing during the run must not affect the result.
        applyStimulus(16'h8000, 16'h0002, 1'b1);
        checkOutput("scrambled_inputs", 32'h0001_0000, 1'b0);

        // Random operand pairs with a reset between operations.
        for (int n = 0; n < 1000; n++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            case ($urandom_range(0, 7))
                0: a = 16'h0;
                1: b = 16'h0;
                2: a = 16'hFFFF;
                3: b = 16'hFFFF;
                4: b = 16'(1 << $urandom_range(0, 15));
                default: ;
            endcase
            applyStimulus(a, b, 1'b0);
            rst_n = 1'b0;
            @(posedge clk);
            #1;
            rst_n = 1'b1;
            checkOutput("reset_between", 32'h0, 1'b0);
        end

        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (sb.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
